mem_port_arbiter: RTL and testbench

- Shares one single-port, fixed-latency unified memory between the instruction-fetch stage and the data-memory stage of the pipelined MIPS core.
- Arbitrates requests, sequences each multi-cycle access and returns read data per port.
- Generates per-stage stall signals that the hazard logic ORs into its PC and pipeline-register stalls.
- Data accesses have priority; a starvation counter guarantees fetch progress.

---
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between the fetch and data stages.
// Data wins arbitration, but a fetch that loses STARVE_LIMIT times in a row wins the next one.
module mem_port_arbiter #(
  parameter int unsigned MEM_LATENCY  = 2,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        busy
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAT_LOAD   = CNT_W'(MEM_LATENCY - 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} arbStateT;

  arbStateT         state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic [CNT_W-1:0] starveCnt, starveCntNext;
  logic             ownerDm, ownerDmNext;
  logic             reqWe, reqWeNext;
  logic [31:0]      memAddrNext, memWdataNext;
  logic [31:0]      ifRdataNext, dmRdataNext;
  logic             ifReadyNext, dmReadyNext;
  logic             memEnNext, memWeNext, busyNext;
  logic             grantIf;

  // State register and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      starveCnt <= '0;
      ownerDm   <= 1'b0;
      reqWe     <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_ready  <= 1'b0;
      dm_ready  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= stateNext;
      cnt       <= cntNext;
      starveCnt <= starveCntNext;
      ownerDm   <= ownerDmNext;
      reqWe     <= reqWeNext;
      mem_addr  <= memAddrNext;
      mem_wdata <= memWdataNext;
      mem_en    <= memEnNext;
      mem_we    <= memWeNext;
      if_rdata  <= ifRdataNext;
      dm_rdata  <= dmRdataNext;
      if_ready  <= ifReadyNext;
      dm_ready  <= dmReadyNext;
      busy      <= busyNext;
    end
  end

  // Arbitration, access sequencing and next-cycle output values
  always_comb begin
    stateNext     = state;
    cntNext       = cnt;
    starveCntNext = starveCnt;
    ownerDmNext   = ownerDm;
    reqWeNext     = reqWe;
    memAddrNext   = mem_addr;
    memWdataNext  = mem_wdata;
    ifRdataNext   = if_rdata;
    dmRdataNext   = dm_rdata;
    ifReadyNext   = 1'b0;
    dmReadyNext   = 1'b0;
    memEnNext     = 1'b0;
    memWeNext     = 1'b0;
    grantIf       = 1'b0;

    unique case (state)
      IDLE: begin
        if (if_req || dm_req) begin
          grantIf      = if_req && (!dm_req || (starveCnt == STARVE_MAX));
          ownerDmNext  = !grantIf;
          reqWeNext    = !grantIf && dm_we;
          memAddrNext  = grantIf ? if_addr : dm_addr;
          memWdataNext = grantIf ? mem_wdata : dm_wdata;
          cntNext      = LAT_LOAD;
          memEnNext    = 1'b1;
          memWeNext    = reqWeNext;
          stateNext    = ACCESS;
          if (grantIf) begin
            starveCntNext = '0;
          end else if (if_req && (starveCnt != STARVE_MAX)) begin
            starveCntNext = starveCnt + 1'b1;
          end
        end
      end
      ACCESS: begin
        if (cnt == '0) begin
          // Read data is only valid in the final access cycle
          if (!reqWe) begin
            if (ownerDm) dmRdataNext = mem_rdata;
            else         ifRdataNext = mem_rdata;
          end
          ifReadyNext = !ownerDm;
          dmReadyNext = ownerDm;
          stateNext   = RESP;
        end else begin
          cntNext   = cnt - 1'b1;
          memEnNext = 1'b1;
          memWeNext = reqWe;
        end
      end
      RESP: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase

    busyNext = (stateNext != IDLE);
  end

  // Stalls follow the request directly so the hazard unit sees them in the request cycle
  assign stall_if  = if_req & ~if_ready & ~rst;
  assign stall_mem = dm_req & ~dm_ready & ~rst;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model, directed scenarios and
// randomized two-requester traffic with occasional asynchronous resets.
module tb_mem_port_arbiter;

  localparam int unsigned LAT    = 3;
  localparam int unsigned STARVE = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_ready, dm_ready, mem_en, mem_we, stall_if, stall_mem, busy;

  int checks = 0;
  int failures = 0;

  mem_port_arbiter #(.MEM_LATENCY(LAT), .STARVE_LIMIT(STARVE)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: one transaction at a time, tracked by its cycle offset from the grant.
  bit          mActive, mOwnerDm, mWe, mGiveIf;
  int unsigned mPhase;
  int unsigned mStarve;
  logic [31:0] mAddr, mWdata, mIfRdata, mDmRdata;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mActive = 0; mOwnerDm = 0; mWe = 0; mPhase = 0; mStarve = 0;
      mAddr = '0; mWdata = '0; mIfRdata = '0; mDmRdata = '0;
    end else if (!mActive) begin
      if (if_req || dm_req) begin
        mGiveIf = if_req && (!dm_req || mStarve == STARVE);
        if (mGiveIf) mStarve = 0;
        else if (if_req && mStarve < STARVE) mStarve = mStarve + 1;
        mOwnerDm = !mGiveIf;
        mWe      = !mGiveIf && dm_we;
        mAddr    = mGiveIf ? if_addr : dm_addr;
        mWdata   = dm_wdata;
        mActive  = 1;
        mPhase   = 1;
      end
    end else if (mPhase == LAT) begin
      if (!mWe) begin
        if (mOwnerDm) mDmRdata = mem_rdata;
        else          mIfRdata = mem_rdata;
      end
      mPhase = LAT + 1;
    end else if (mPhase == LAT + 1) begin
      mActive = 0;
    end else begin
      mPhase = mPhase + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compareLoop();
    bit eMemEn, eIfRdy, eDmRdy;
    forever begin
      @(negedge clk);
      if (!rst) begin
        eMemEn = mActive && (mPhase <= LAT);
        eIfRdy = mActive && (mPhase == LAT + 1) && !mOwnerDm;
        eDmRdy = mActive && (mPhase == LAT + 1) && mOwnerDm;
        chk("busy", 32'(busy), 32'(mActive));
        chk("mem_en", 32'(mem_en), 32'(eMemEn));
        chk("mem_we", 32'(mem_we), 32'(eMemEn && mWe));
        if (eMemEn) chk("mem_addr", mem_addr, mAddr);
        if (eMemEn && mWe) chk("mem_wdata", mem_wdata, mWdata);
        chk("if_ready", 32'(if_ready), 32'(eIfRdy));
        chk("dm_ready", 32'(dm_ready), 32'(eDmRdy));
        chk("if_rdata", if_rdata, mIfRdata);
        chk("dm_rdata", dm_rdata, mDmRdata);
        chk("stall_if", 32'(stall_if), 32'(if_req && !eIfRdy));
        chk("stall_mem", 32'(stall_mem), 32'(dm_req && !eDmRdy));
      end
    end
  endtask

  task automatic checkZeros(input string tag);
    chk({tag, "_flags"}, 32'({busy, mem_en, mem_we, if_ready, dm_ready, stall_if, stall_mem}), 32'h0);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk({tag, "_if_rdata"}, if_rdata, 32'h0);
    chk({tag, "_dm_rdata"}, dm_rdata, 32'h0);
  endtask

  // Count negedges until each ready pulse; requests drop right after their ready.
  task automatic watch(input int maxN, input logic [31:0] rdataAfter, output int ifAt, output int dmAt);
    ifAt = -1; dmAt = -1;
    for (int n = 1; n <= maxN; n++) begin
      @(negedge clk);
      if (if_ready && ifAt < 0) ifAt = n;
      if (dm_ready && dmAt < 0) dmAt = n;
      #1;
      if (if_ready || dm_ready) mem_rdata = rdataAfter;
      if (if_ready) if_req = 0;
      if (dm_ready) dm_req = 0;
      if (!if_req && !dm_req) break;
    end
  endtask

  initial begin
    int ifAt, dmAt, grants;
    logic [5:0] order;

    rst = 1; if_req = 0; dm_req = 0; dm_we = 0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
    fork compareLoop(); join_none

    // Reset held with both requests high
    if_req = 1; if_addr = 32'h100; dm_req = 1; dm_addr = 32'h40; mem_rdata = 32'h0000ABCD;
    repeat (2) @(negedge clk);
    checkZeros("reset_hold");
    #1 rst = 0;
    watch(40, 32'h11112222, ifAt, dmAt);
    chk("both_dm_ready_cycle", 32'(dmAt), 32'(LAT + 1));
    chk("both_if_ready_cycle", 32'(ifAt), 32'(2 * LAT + 3));
    chk("both_dm_rdata", dm_rdata, 32'h0000ABCD);
    chk("both_if_rdata", if_rdata, 32'h11112222);

    // Single fetch
    @(negedge clk); #1;
    if_req = 1; if_addr = 32'h10; mem_rdata = 32'h8C220004;
    watch(40, 32'h0, ifAt, dmAt);
    chk("fetch_ready_cycle", 32'(ifAt), 32'(LAT + 1));
    chk("fetch_rdata", if_rdata, 32'h8C220004);

    // Data write: strobes stable across the access, load data untouched
    @(negedge clk); #1;
    dm_req = 1; dm_we = 1; dm_addr = 32'h20; dm_wdata = 32'hDEADBEEF; mem_rdata = 32'h55555555;
    for (int n = 1; n <= LAT + 1; n++) begin
      @(negedge clk);
      if (n <= LAT) begin
        chk("write_strobes", 32'({mem_en, mem_we}), 32'h3);
        chk("write_wdata", mem_wdata, 32'hDEADBEEF);
        chk("write_addr", mem_addr, 32'h20);
      end else begin
        chk("write_ready", 32'(dm_ready), 32'h1);
      end
    end
    #1 dm_req = 0; dm_we = 0;
    chk("write_keeps_dm_rdata", dm_rdata, 32'h0000ABCD);

    // Starvation: both requests held continuously from a clean reset
    @(negedge clk); #1 rst = 1;
    @(negedge clk); #1 rst = 0;
    if_req = 1; dm_req = 1; order = '0; grants = 0;
    for (int n = 0; n < 80 && grants < 6; n++) begin
      @(negedge clk);
      if (if_ready || dm_ready) begin
        order = {order[4:0], if_ready};
        grants++;
      end
    end
    #1 if_req = 0; dm_req = 0;
    chk("starve_grants", 32'(grants), 32'd6);
    chk("starve_order", 32'(order), 32'(6'b001001));

    // Reset during a fetch access
    @(negedge clk); @(negedge clk); #1;
    if_req = 1; if_addr = 32'h44; mem_rdata = 32'h00000099;
    @(negedge clk); #1 rst = 1;
    #1 checkZeros("reset_async");
    @(negedge clk);
    checkZeros("reset_mid");
    #1 rst = 0;
    watch(40, 32'h0, ifAt, dmAt);
    chk("post_reset_fetch_cycle", 32'(ifAt), 32'(LAT + 1));
    chk("post_reset_fetch_rdata", if_rdata, 32'h00000099);

    // Randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk); #1;
      mem_rdata = $urandom;
      if (rst) rst = 0;
      else if ($urandom_range(0, 299) == 0) begin
        rst = 1;
        #1 checkZeros("reset_random");
      end
      if (if_req) begin
        if (if_ready) begin if_req = 1'($urandom_range(0, 1)); if_addr = $urandom; end
        else if ($urandom_range(0, 15) == 0) if_req = 0;
        else if ($urandom_range(0, 7) == 0) if_addr = $urandom;
      end else if ($urandom_range(0, 2) == 0) begin
        if_req = 1; if_addr = $urandom;
      end
      if (dm_req) begin
        if (dm_ready) begin
          dm_req = 1'($urandom_range(0, 1)); dm_we = 1'($urandom_range(0, 1));
          dm_addr = $urandom; dm_wdata = $urandom;
        end else if ($urandom_range(0, 15) == 0) dm_req = 0;
        else if ($urandom_range(0, 7) == 0) dm_wdata = $urandom;
      end else if ($urandom_range(0, 2) == 0) begin
        dm_req = 1; dm_we = 1'($urandom_range(0, 1)); dm_addr = $urandom; dm_wdata = $urandom;
      end
    end
    if_req = 0; dm_req = 0; rst = 0;
    repeat (LAT + 4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
